// File: rtl/peak_amplitude_meter.sv
// Windowed peak/min tracker with averaged half peak-to-peak amplitude readout.
// Consumes a sparse valid/data sample stream; one amp_valid pulse per 2^lgavg windows.
module peak_amplitude_meter #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int MAXLG = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          data_valid,
  input  logic [DW-1:0] data_in,
  input  logic [CW-1:0] win_len,
  input  logic [3:0]    lgavg,
  output logic [DW-1:0] peak_max,
  output logic [DW-1:0] peak_min,
  output logic [DW-1:0] amp_out,
  output logic          amp_valid,
  output logic          busy
);

  localparam int AW = DW + MAXLG;

  typedef enum logic {IDLE, ACQ} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]        cnt, wl_q, wl_in_c;
  logic [3:0]           lg_q, lg_in_c;
  logic [MAXLG-1:0]     avg_cnt, avg_mask;
  logic [AW-1:0]        acc, amp_sum;
  logic signed [DW-1:0] din_s, run_max, run_min, new_max, new_min;
  logic [DW:0]          pp;
  logic [DW-1:0]        half;
  logic                 first, last_sample, group_done, sample_en;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = ACQ;
      ACQ:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ACQ);

  always_comb begin
    din_s       = data_in;
    wl_in_c     = (win_len < CW'(2)) ? CW'(2) : win_len;
    lg_in_c     = (lgavg > 4'(MAXLG)) ? 4'(MAXLG) : lgavg;
    first       = (cnt == '0);
    new_max     = (first || din_s > run_max) ? din_s : run_max;
    new_min     = (first || din_s < run_min) ? din_s : run_min;
    // Sign-extend by one bit so max-min never wraps, even for full-scale swings.
    pp          = {new_max[DW-1], new_max} - {new_min[DW-1], new_min};
    half        = DW'(pp >> 1);
    amp_sum     = acc + AW'(half);
    last_sample = (cnt == wl_q - CW'(1));
    avg_mask    = ~({MAXLG{1'b1}} << lg_q);
    group_done  = (avg_cnt == avg_mask);
    sample_en   = (state == ACQ) && en && data_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      wl_q      <= '0;
      lg_q      <= '0;
      avg_cnt   <= '0;
      acc       <= '0;
      run_max   <= '0;
      run_min   <= '0;
      peak_max  <= '0;
      peak_min  <= '0;
      amp_out   <= '0;
      amp_valid <= 1'b0;
    end else begin
      amp_valid <= 1'b0;
      if (state == IDLE && en) begin
        wl_q    <= wl_in_c;
        lg_q    <= lg_in_c;
        cnt     <= '0;
        avg_cnt <= '0;
        acc     <= '0;
      end else if (sample_en) begin
        if (last_sample) begin
          peak_max <= new_max;
          peak_min <= new_min;
          cnt      <= '0;
          if (group_done) begin
            amp_out   <= DW'(amp_sum >> lg_q);
            amp_valid <= 1'b1;
            acc       <= '0;
            avg_cnt   <= '0;
            // Parameter changes are only picked up between average groups.
            wl_q      <= wl_in_c;
            lg_q      <= lg_in_c;
          end else begin
            acc     <= amp_sum;
            avg_cnt <= avg_cnt + MAXLG'(1);
          end
        end else begin
          run_max <= new_max;
          run_min <= new_min;
          cnt     <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_peak_amplitude_meter.sv
// Directed bench for peak_amplitude_meter: expected pulses are queued by the driver
// and popped by an independent monitor that also checks the one-cycle pulse latency.
module tb_peak_amplitude_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] win_len = '0;
  logic [3:0]  lgavg = '0;
  logic [15:0] peak_max, peak_min, amp_out;
  logic        amp_valid, busy;

  typedef struct {
    logic [15:0] amp;
    logic [15:0] pmax;
    logic [15:0] pmin;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t next_exp;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  peak_amplitude_meter #(.DW(16), .CW(16), .MAXLG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .data_valid(data_valid),
    .data_in   (data_in),
    .win_len   (win_len),
    .lgavg     (lgavg),
    .peak_max  (peak_max),
    .peak_min  (peak_min),
    .amp_out   (amp_out),
    .amp_valid (amp_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every amp_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && amp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_amp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("amp_out",      amp_out,  e.amp);
        check("peak_max",     peak_max, e.pmax);
        check("peak_min",     peak_min, e.pmin);
        check("pulse_cycle",  cyc,      e.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at a negedge after gap idle cycles.
  task automatic drive(input logic [15:0] d, input int gap, input bit fin);
    data_in    = d;
    data_valid = 1'b1;
    if (fin) begin
      next_exp.due = cyc + 1;
      sb.push_back(next_exp);
    end
    @(negedge clk);
    data_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic start(input logic [15:0] wl, input logic [3:0] lg);
    en = 1'b0;
    @(negedge clk);
    win_len = wl;
    lgavg   = lg;
    en      = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_exp(input logic [15:0] a, input logic [15:0] mx, input logic [15:0] mn);
    next_exp.amp  = a;
    next_exp.pmax = mx;
    next_exp.pmin = mn;
    next_exp.due  = 0;
  endtask

  initial begin
    logic [15:0] d;
    int          a;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_peak_max", peak_max, 16'h0000);
    check("rst_peak_min", peak_min, 16'h0000);
    check("rst_amp_out",  amp_out,  16'h0000);
    check("rst_amp_vld",  amp_valid, 1'b0);
    check("rst_busy",     busy,     1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Constant 0x0123, valid every 40 clocks, two windows
    start(16'd64, 4'd0);
    check("busy_after_en", busy, 1'b1);
    set_exp(16'd0, 16'h0123, 16'h0123);
    for (int i = 0; i < 128; i++) drive(16'h0123, 39, (i % 64) == 63);

    // Square wave +-1000, period 20 samples
    start(16'd64, 4'd0);
    set_exp(16'd1000, 16'd1000, 16'hFC18);
    for (int i = 0; i < 64; i++) begin
      d = ((i / 10) % 2 == 0) ? 16'd1000 : 16'hFC18;
      drive(d, 0, i == 63);
    end

    // Full-scale alternation: pp = 65535 must not wrap
    start(16'd4, 4'd0);
    set_exp(16'd32767, 16'h7FFF, 16'h8000);
    for (int i = 0; i < 8; i++) drive((i % 2 == 0) ? 16'h7FFF : 16'h8000, 0, (i % 4) == 3);

    // Average over four windows of amplitude 100..400
    start(16'd8, 4'd2);
    set_exp(16'd250, 16'd400, 16'hFE70);
    for (int w = 0; w < 4; w++) begin
      a = 100 * (w + 1);
      for (int i = 0; i < 8; i++) begin
        d = (i % 2 == 0) ? 16'(a) : 16'(-a);
        drive(d, 0, (w == 3) && (i == 7));
      end
      if (w == 0) begin
        check("avg_w1_no_pulse", amp_valid, 1'b0);
        check("avg_w1_peak_max", peak_max, 16'd100);
        check("avg_w1_peak_min", peak_min, 16'hFF9C);
      end
    end

    // win_len=1 clamps to 2; ramp gives pp=1, half=0
    start(16'd1, 4'd0);
    set_exp(16'd0, 16'd1, 16'd0);
    drive(16'd0, 1, 1'b0);
    drive(16'd1, 1, 1'b1);
    set_exp(16'd0, 16'd3, 16'd2);
    drive(16'd2, 1, 1'b0);
    drive(16'd3, 1, 1'b1);

    // Drop en mid-window: partial discarded, outputs held
    start(16'd64, 4'd0);
    for (int i = 0; i < 30; i++) drive((i % 2 == 0) ? 16'd700 : 16'hFED4, 1, 1'b0);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy",     busy,     1'b0);
    check("abort_peak_max", peak_max, 16'd3);
    check("abort_peak_min", peak_min, 16'd2);
    repeat (3) @(negedge clk);
    start(16'd64, 4'd0);
    set_exp(16'd500, 16'd700, 16'hFED4);
    for (int i = 0; i < 64; i++) drive((i % 2 == 0) ? 16'd700 : 16'hFED4, 1, i == 63);

    // Asynchronous reset mid-window
    start(16'd64, 4'd0);
    for (int i = 0; i < 10; i++) drive(16'd50, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_peak_max", peak_max, 16'h0000);
    check("arst_peak_min", peak_min, 16'h0000);
    check("arst_amp_out",  amp_out,  16'h0000);
    check("arst_busy",     busy,     1'b0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peak_amplitude_meter.md
Name: peak_amplitude_meter

Overview:
- Downstream of FIR_filter in the lock-in chain; consumes the filter's `valid`/`data_out` sample stream.
- Measures signal amplitude per window: tracks max/min over a programmable number of valid samples, computes half peak-to-peak, and averages that over 2^lgavg windows.
- Replaces bench-side decimation and boxcar averaging with a synthesizable amplitude readout for filter-gain characterisation.

Parameters:
- DW, 16, sample width (signed two's complement).
- CW, 16, window-length counter width.
- MAXLG, 4, maximum supported lgavg; accumulator width is DW+MAXLG.

Ports:
- clk  in  1  system clock (40 MHz).
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  measurement enable; low forces IDLE.
- data_valid  in  1  sample strobe, connected to FIR_filter valid.
- data_in  in  DW  signed sample, connected to FIR_filter data_out.
- win_len  in  CW  valid samples per window.
- lgavg  in  4  log2 of windows averaged; values >MAXLG clamp to MAXLG.
- peak_max  out  DW  signed max of last completed window.
- peak_min  out  DW  signed min of last completed window.
- amp_out  out  DW  unsigned averaged half peak-to-peak.
- amp_valid  out  1  one-cycle pulse when amp_out updates.
- busy  out  1  high in ACQ.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; counters, accumulator and running max/min cleared.
- States: IDLE, ACQ.
- IDLE -> ACQ when en=1. Latch win_len into wl_q (clamped: win_len<2 gives 2) and lgavg into lg_q (clamped to MAXLG). Clear window count, window-average count and accumulator.
- ACQ -> IDLE whenever en=0, regardless of window progress.
  - The partial window is discarded and amp_valid is not pulsed.
  - peak_max, peak_min and amp_out hold their last values.
- Counters advance only on clock edges where data_valid=1. Gaps of any length between valid samples are legal.
- First valid sample of a window loads run_max = run_min = data_in.
- Each later valid sample updates run_max and run_min using signed comparison.
- Final sample (count == wl_q-1 with data_valid=1), all on the same edge:
  - Include the final sample in the extremes.
  - Write the final extremes to peak_max/peak_min.
  - pp = max-min, computed DW+1 bits unsigned, range 0..65535 at DW=16.
  - half = pp>>1, DW bits.
  - acc += half.
  - Reset count to 0, so the next valid sample starts a new window with no dead cycle.
- Average complete (window-average count reaches 2^lg_q-1 on a final-sample edge), on that same edge:
  - amp_out = (acc+half)>>lg_q, truncating.
  - amp_valid = 1 for exactly one cycle.
  - Clear acc and the window-average count.
- Latency: amp_valid/amp_out are registered on the edge that samples the final data_valid, so they are visible in the following cycle.
- win_len and lgavg are re-latched at every average-group boundary. Changes mid-group take effect at the next group.
- busy = (state==ACQ).
- Reset mid-operation aborts immediately, with all outputs returning to 0.
- No overflow is possible: acc has DW+MAXLG bits and holds at most 2^MAXLG × (2^DW-1)/2.

Test Plan:
- Constant input 0x0123, win_len=64, lgavg=0, valid every 40 clocks -> amp_valid every 64 valid samples; amp_out=0; peak_max=peak_min=0x0123.
- Square wave ±1000 (period 20 samples), win_len=64, lgavg=0 -> amp_out=1000, peak_max=1000, peak_min=-1000, pulse one clock after the 64th valid.
- Alternating 32767/-32768, win_len=4, lgavg=0 -> amp_out=32767 (pp=65535 with no wrap), peak_min=0x8000.
- lgavg=2, four consecutive windows with square-wave amplitudes 100, 200, 300, 400 -> single amp_valid after the 4th window, amp_out=250; no pulse after windows 1-3.
- win_len=1, ramp input 0,1,2,3 -> clamped to 2, amp_valid after the 2nd and 4th valid, amp_out=0 each time (pp=1 gives 0).
- en dropped after 30 of 64 samples, then raised -> no amp_valid, busy falls next cycle; fresh window starts, first pulse after 64 new valid samples.
- rst_n pulsed low mid-window -> all outputs 0 immediately (async), state IDLE.
